lcd_text_scanout: RTL and testbench
===================================

Name: lcd_text_scanout

Overview:
- Text-mode scanout stage sitting directly downstream of the 1024x8 VRAM read port.
- Tracks the LCD timing stream (de/hsync/vsync) and generates VRAM read addresses for a 60x17 grid of 8x16 character cells (480x272 panel).
- Looks each character up in an external synchronous font ROM and emits RGB565 pixels, with timing re-aligned to the pixel data.
- Overlays a blinking inverted-cell cursor.

Parameters:
- COLS, 60, character columns per row
- ROWS, 17, character rows per frame
- FG_RGB, 16'hFFFF, foreground colour, RGB565
- BG_RGB, 16'h0000, background colour, RGB565
- SYNC_ACTIVE, 1'b0, asserted level of hsync_in/vsync_in
- BLINK_BIT, 4, frame-counter bit that gates cursor visibility

Ports:
- clk  in  1  pixel clock; also drives the VRAM read-port clock
- reset  in  1  asynchronous reset, active-high
- de_in  in  1  data enable from the LCD timing generator
- hsync_in  in  1  hsync from the timing generator
- vsync_in  in  1  vsync from the timing generator
- vram_adb  out  10  VRAM read address
- vram_ceb  out  1  VRAM read clock enable
- vram_dout  in  8  VRAM read data; valid 1 clk after address
- font_addr  out  12  {char[7:0], glyph_line[3:0]}
- font_data  in  8  glyph row; valid 1 clk after font_addr; MSB = leftmost pixel
- cursor_addr  in  10  cell index of the cursor, row*COLS+col
- cursor_en  in  1  cursor enable
- lcd_r  out  5  red
- lcd_g  out  6  green
- lcd_b  out  5  blue
- lcd_de  out  1  de_in delayed 3 clk
- lcd_hsync  out  1  hsync_in delayed 3 clk
- lcd_vsync  out  1  vsync_in delayed 3 clk

Behaviour:
- Reset (async, active-high, may assert mid-frame) clears:
  - all counters and pipeline registers;
  - outputs to: lcd_r/g/b=0, lcd_de=0, lcd_hsync=lcd_vsync=~SYNC_ACTIVE, vram_ceb=0, vram_adb=0, font_addr=0.
- Counters (registered):
  - px 0..7, col 0..COLS-1, line 0..15, row 0..ROWS, row_base (10b).
  - vram_adb = row_base + col, combinational from the registers.
- Clk with de_in=1: px++. On px 7->0, col++, saturating at COLS-1; extra pixels in the line render BG.
- de_in falling edge (de_d1 & ~de_in):
  - px=0, col=0, line++.
  - On line 15->0: row++ and row_base += COLS.
- Vsync asserted edge:
  - px, col, line, row, row_base cleared.
  - frame_cnt (8b) increments, wrapping 255->0.
  - Vsync level held asserted keeps the counters cleared.
- vram_ceb = de_in & (row < ROWS). Once row reaches ROWS, no VRAM reads occur and pixels render BG until the next vsync.
- Pipeline (cycle n = pixel presented on de_in):
  - n: adb driven.
  - n+1: font_addr = {vram_dout, line_d1} (combinational); px, de, valid and cursor-hit delayed alongside.
  - n+2: font_data valid.
  - n+3: registered RGB out.
  - Total latency is exactly 3 clk. lcd_de, lcd_hsync and lcd_vsync are 3-stage shift copies of their inputs.
- Pixel: bit = font_data[7-px_d2].
  - cursor_hit = cursor_en & frame_cnt[BLINK_BIT] & (row_base+col == cursor_addr), sampled at n and delayed.
  - pix = bit ^ cursor_hit.
  - Output FG_RGB if de_d2 & valid_d2 & pix; BG_RGB if de_d2 & ~(valid_d2 & pix); 0 when de_d2=0.
- Counters are unaffected by hsync_in. Line advance keys only off de falling edges.
- Simultaneous de falling edge and vsync edge in the same clk: vsync clear wins.

Decomposition:
- Shared package holds:
  - LCD_COLS=60, LCD_ROWS=17, GLYPH_W=8, GLYPH_H=16, VRAM_AW=10;
  - RGB565 typedef and colour constants.
- One natural sub-module: text_scan_counter (px/col/line/row/row_base generation plus vsync/de edge detection).
- Pipeline and colour mux stay in the top.

Test Plan:
- Reset mid-line, release, 1 vsync edge, de high 8 clk with row 0 col 0 => vram_adb=0, then 1 on the 9th clk; lcd_de rises exactly 3 clk after de_in.
- VRAM model returns 8'h41 for addr 0; font model returns 8'hA5 for 12'h410 => first 8 output pixels on line 0 are FG,BG,FG,BG,BG,FG,BG,FG.
- 16 de-pulses after vsync => row_base=60, so vram_adb=60 at the first pixel of line 16; after 272 lines row=17, vram_ceb stays 0 and pixels are BG_RGB.
- cursor_addr=61, cursor_en=1, frame_cnt bit4=1 => cell (1,1) pixels inverted (font 8'h00 renders FG); at frame_cnt bit4=0 the same cell renders BG.
- de held high 500 clk on one line => col saturates at 59, extra pixels are BG, vram_ceb still tracks de_in.
- vsync edge and de falling edge in the same clk => line=0, row_base=0 next cycle, frame_cnt +1.

Source files
------------

// File: rtl/lcd_text_scanout_pkg.sv
// Shared constants and types for the text-mode LCD scanout.
//   LCD_COLS/LCD_ROWS : character grid (60x17 cells on a 480x272 panel)
//   GLYPH_W/GLYPH_H   : character cell size in pixels (8x16)
//   VRAM_AW           : VRAM address width (1024 cells)
//   rgb565_t          : packed RGB565 pixel
package lcd_text_scanout_pkg;

  localparam int unsigned LCD_COLS = 60;
  localparam int unsigned LCD_ROWS = 17;
  localparam int unsigned GLYPH_W  = 8;
  localparam int unsigned GLYPH_H  = 16;
  localparam int unsigned VRAM_AW  = 10;
  localparam int unsigned PX_W     = $clog2(GLYPH_W);
  localparam int unsigned LINE_W   = $clog2(GLYPH_H);

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam rgb565_t RGB_WHITE = 16'hFFFF;
  localparam rgb565_t RGB_BLACK = 16'h0000;

endpackage

// File: rtl/lcd_text_scanout_counter.sv
// Scan position tracker for the text scanout.
//   clk, reset      : pixel clock, async active-high reset
//   de_in, vsync_in : timing stream from the LCD timing generator
//   px, line        : pixel within the glyph row, glyph line within the cell
//   cell_addr       : row_base + col, the VRAM address of the current cell
//   row_active      : row < ROWS (frame still inside the character grid)
//   col_done        : pixels past the last column of the current line
//   blink           : frame counter bit used for cursor blinking
module text_scan_counter
  import lcd_text_scanout_pkg::*;
#(
  parameter int unsigned COLS        = LCD_COLS,
  parameter int unsigned ROWS        = LCD_ROWS,
  parameter logic        SYNC_ACTIVE = 1'b0,
  parameter int unsigned BLINK_BIT   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               de_in,
  input  logic               vsync_in,
  output logic [PX_W-1:0]    px,
  output logic [LINE_W-1:0]  line,
  output logic [VRAM_AW-1:0] cell_addr,
  output logic               row_active,
  output logic               col_done,
  output logic               blink
);

  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_W = $clog2(ROWS + 1);

  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [VRAM_AW-1:0] row_base;
  logic [7:0]         frame_cnt;
  logic               de_d1;
  logic               vs_act_d1;
  logic               vs_act;
  logic               de_fall;
  logic               vs_edge;

  assign vs_act     = (vsync_in == SYNC_ACTIVE);
  assign de_fall    = de_d1 & ~de_in;
  assign vs_edge    = vs_act & ~vs_act_d1;
  assign cell_addr  = row_base + VRAM_AW'(col);
  assign row_active = (row < ROW_W'(ROWS));
  assign blink      = frame_cnt[BLINK_BIT];

  // Vsync (level) has priority over a coincident de falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      px        <= '0;
      col       <= '0;
      col_done  <= 1'b0;
      line      <= '0;
      row       <= '0;
      row_base  <= '0;
      frame_cnt <= '0;
      de_d1     <= 1'b0;
      vs_act_d1 <= 1'b0;
    end else begin
      de_d1     <= de_in;
      vs_act_d1 <= vs_act;
      if (vs_edge) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (vs_act) begin
        px       <= '0;
        col      <= '0;
        col_done <= 1'b0;
        line     <= '0;
        row      <= '0;
        row_base <= '0;
      end else if (de_fall) begin
        px       <= '0;
        col      <= '0;
        col_done <= 1'b0;
        line     <= line + LINE_W'(1);
        // row saturates at ROWS so row_base never wraps past the grid
        if (line == LINE_W'(GLYPH_H - 1) && row_active) begin
          row      <= row + ROW_W'(1);
          row_base <= row_base + VRAM_AW'(COLS);
        end
      end else if (de_in) begin
        px <= px + PX_W'(1);
        if (px == PX_W'(GLYPH_W - 1)) begin
          if (col == COL_W'(COLS - 1)) begin
            col_done <= 1'b1;
          end else begin
            col <= col + COL_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/lcd_text_scanout.sv
// Text-mode scanout: VRAM cell fetch -> font ROM lookup -> RGB565 pixel.
//   clk, reset                    : pixel clock, async active-high reset
//   de_in, hsync_in, vsync_in     : LCD timing stream in
//   vram_adb, vram_ceb, vram_dout : VRAM read port (data 1 clk after address)
//   font_addr, font_data          : font ROM port {char, glyph line} -> row bits
//   cursor_addr, cursor_en        : blinking inverted-cell cursor
//   lcd_r/g/b, lcd_de/hsync/vsync : pixel out, timing delayed 3 clk to match
module lcd_text_scanout
  import lcd_text_scanout_pkg::*;
#(
  parameter int unsigned COLS        = LCD_COLS,
  parameter int unsigned ROWS        = LCD_ROWS,
  parameter rgb565_t     FG_RGB      = RGB_WHITE,
  parameter rgb565_t     BG_RGB      = RGB_BLACK,
  parameter logic        SYNC_ACTIVE = 1'b0,
  parameter int unsigned BLINK_BIT   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                de_in,
  input  logic                hsync_in,
  input  logic                vsync_in,
  output logic [VRAM_AW-1:0]  vram_adb,
  output logic                vram_ceb,
  input  logic [7:0]          vram_dout,
  output logic [11:0]         font_addr,
  input  logic [7:0]          font_data,
  input  logic [VRAM_AW-1:0]  cursor_addr,
  input  logic                cursor_en,
  output logic [4:0]          lcd_r,
  output logic [5:0]          lcd_g,
  output logic [4:0]          lcd_b,
  output logic                lcd_de,
  output logic                lcd_hsync,
  output logic                lcd_vsync
);

  logic [PX_W-1:0]    px;
  logic [LINE_W-1:0]  line;
  logic [VRAM_AW-1:0] cell_addr;
  logic               row_active;
  logic               col_done;
  logic               blink;

  text_scan_counter #(
    .COLS        (COLS),
    .ROWS        (ROWS),
    .SYNC_ACTIVE (SYNC_ACTIVE),
    .BLINK_BIT   (BLINK_BIT)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .de_in      (de_in),
    .vsync_in   (vsync_in),
    .px         (px),
    .line       (line),
    .cell_addr  (cell_addr),
    .row_active (row_active),
    .col_done   (col_done),
    .blink      (blink)
  );

  logic              valid;
  logic              cursor_hit;
  logic              de_d1, de_d2;
  logic              valid_d1, valid_d2;
  logic              hit_d1, hit_d2;
  logic [PX_W-1:0]   px_d1, px_d2;
  logic [LINE_W-1:0] line_d1;
  logic [2:0]        hs_sr, vs_sr;
  logic              pix;
  rgb565_t           rgb_q;

  assign vram_adb   = cell_addr;
  assign vram_ceb   = de_in & row_active & ~reset;
  assign valid      = de_in & row_active & ~col_done;
  assign cursor_hit = cursor_en & blink & (cell_addr == cursor_addr);

  // Gated so the ROM address idles at zero outside valid cells (and in reset).
  assign font_addr  = valid_d1 ? {vram_dout, line_d1} : '0;
  assign pix        = font_data[PX_W'(GLYPH_W - 1) - px_d2] ^ hit_d2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_d1    <= 1'b0;
      de_d2    <= 1'b0;
      valid_d1 <= 1'b0;
      valid_d2 <= 1'b0;
      hit_d1   <= 1'b0;
      hit_d2   <= 1'b0;
      px_d1    <= '0;
      px_d2    <= '0;
      line_d1  <= '0;
      hs_sr    <= {3{~SYNC_ACTIVE}};
      vs_sr    <= {3{~SYNC_ACTIVE}};
      lcd_de   <= 1'b0;
      rgb_q    <= '0;
    end else begin
      de_d1    <= de_in;
      de_d2    <= de_d1;
      valid_d1 <= valid;
      valid_d2 <= valid_d1;
      hit_d1   <= cursor_hit;
      hit_d2   <= hit_d1;
      px_d1    <= px;
      px_d2    <= px_d1;
      line_d1  <= line;
      hs_sr    <= {hs_sr[1:0], hsync_in};
      vs_sr    <= {vs_sr[1:0], vsync_in};
      lcd_de   <= de_d2;
      if (!de_d2) begin
        rgb_q <= '0;
      end else if (valid_d2 && pix) begin
        rgb_q <= FG_RGB;
      end else begin
        rgb_q <= BG_RGB;
      end
    end
  end

  assign lcd_r     = rgb_q.r;
  assign lcd_g     = rgb_q.g;
  assign lcd_b     = rgb_q.b;
  assign lcd_hsync = hs_sr[2];
  assign lcd_vsync = vs_sr[2];

endmodule

// File: tb/tb_lcd_text_scanout.sv
// Bench for lcd_text_scanout: VRAM/font ROM models, a position-based pixel
// model feeding a 3-deep scoreboard, a first-line vector table, and
// hand-written sequences for reset, row/column limits, vsync priority
// and cursor blink.
module tb_lcd_text_scanout;

  localparam logic [15:0] FG = 16'hFFFF;
  localparam logic [15:0] BG = 16'h0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        de_in = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [9:0]  vram_adb;
  logic        vram_ceb;
  logic [7:0]  vram_dout = 8'h00;
  logic [11:0] font_addr;
  logic [7:0]  font_data = 8'h00;
  logic [9:0]  cursor_addr = 10'd0;
  logic        cursor_en = 1'b0;
  logic [4:0]  lcd_r;
  logic [5:0]  lcd_g;
  logic [4:0]  lcd_b;
  logic        lcd_de, lcd_hsync, lcd_vsync;

  always #5 clk = ~clk;

  lcd_text_scanout dut (
    .clk         (clk),
    .reset       (reset),
    .de_in       (de_in),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .vram_adb    (vram_adb),
    .vram_ceb    (vram_ceb),
    .vram_dout   (vram_dout),
    .font_addr   (font_addr),
    .font_data   (font_data),
    .cursor_addr (cursor_addr),
    .cursor_en   (cursor_en),
    .lcd_r       (lcd_r),
    .lcd_g       (lcd_g),
    .lcd_b       (lcd_b),
    .lcd_de      (lcd_de),
    .lcd_hsync   (lcd_hsync),
    .lcd_vsync   (lcd_vsync)
  );

  function automatic logic [7:0] vram_fn(input logic [9:0] a);
    if (a == 10'd0) return 8'h41;
    if (a[0]) return 8'h20;
    return 8'h30 + {4'h0, a[3:0]};
  endfunction

  function automatic logic [7:0] font_fn(input logic [11:0] fa);
    logic [7:0] ch;
    logic [3:0] ln;
    ch = fa[11:4];
    ln = fa[3:0];
    if (ch == 8'h41) return (ln == 4'd0) ? 8'hA5 : {ln, ~ln};
    if (ch == 8'h20) return 8'h00;
    return ch ^ {ln, ln};
  endfunction

  always @(posedge clk) begin
    if (vram_ceb) vram_dout <= vram_fn(vram_adb);
    font_data <= font_fn(font_addr);
  end

  typedef struct {
    logic [15:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    int          phase;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int phase = 0;

  int m_line = 0, m_pix = 0, m_frames = 0;
  bit m_prev_de = 1'b0, m_prev_vs = 1'b0;

  function automatic string pname(input int p);
    case (p)
      0: return "boot";
      1: return "table";
      2: return "rows";
      3: return "colsat";
      4: return "simul";
      default: return "cursor";
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One pixel clock: compare the output due now, drive inputs, push the
  // expectation for this cycle, then check the combinational VRAM port.
  task automatic cyc(input logic de, input logic hs, input logic vs,
                     input bit use_tab, input logic [15:0] tab_rgb);
    exp_t        e;
    logic [15:0] mrgb;
    int          cell_c, cell_r, bi;
    logic [9:0]  addr;
    logic [7:0]  g;
    logic        hit, vs_act, exp_ceb, chk_adb;
    logic [9:0]  exp_adb;
    @(negedge clk);
    if (sb.size() == 3) begin
      e = sb.pop_front();
      chk({"rgb ", pname(e.phase)}, {lcd_r, lcd_g, lcd_b}, e.rgb);
      chk({"de ", pname(e.phase)}, lcd_de, e.de);
      chk({"hsync ", pname(e.phase)}, lcd_hsync, e.hs);
      chk({"vsync ", pname(e.phase)}, lcd_vsync, e.vs);
    end
    de_in = de;
    hsync_in = hs;
    vsync_in = vs;
    vs_act = (vs == 1'b0);
    mrgb = 16'h0000;
    exp_ceb = 1'b0;
    chk_adb = 1'b0;
    exp_adb = 10'd0;
    if (de) begin
      cell_c = m_pix / 8;
      cell_r = m_line / 16;
      mrgb = BG;
      exp_ceb = (cell_r < 17);
      if (cell_r < 17) begin
        addr = 10'(cell_r * 60 + ((cell_c > 59) ? 59 : cell_c));
        chk_adb = 1'b1;
        exp_adb = addr;
        if (cell_c < 60) begin
          g = font_fn({vram_fn(addr), 4'(m_line % 16)});
          bi = 7 - (m_pix % 8);
          hit = cursor_en & (((m_frames >> 4) & 1) != 0) & (addr == cursor_addr);
          if (g[bi] ^ hit) mrgb = FG;
        end
      end
    end
    if (vs_act) begin
      if (!m_prev_vs) m_frames++;
      m_line = 0;
      m_pix = 0;
    end else if (m_prev_de && !de) begin
      m_line++;
      m_pix = 0;
    end else if (de) begin
      m_pix++;
    end
    m_prev_de = de;
    m_prev_vs = vs_act;
    e.rgb = use_tab ? tab_rgb : mrgb;
    e.de = de;
    e.hs = hs;
    e.vs = vs;
    e.phase = phase;
    sb.push_back(e);
    #1;
    chk({"ceb ", pname(phase)}, vram_ceb, exp_ceb);
    if (chk_adb) chk({"adb ", pname(phase)}, vram_adb, exp_adb);
  endtask

  task automatic px_cyc(input logic de);
    cyc(de, 1'b1, 1'b1, 1'b0, 16'h0);
  endtask

  task automatic do_line(input int npix);
    for (int i = 0; i < npix; i++) px_cyc(1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
  endtask

  task automatic do_vsync();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
  endtask

  // Asserts reset between clock edges (called at negedge+1), holds it,
  // then releases at a negedge with idle inputs.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst rgb", {lcd_r, lcd_g, lcd_b}, 32'h0);
    chk("rst de", lcd_de, 32'h0);
    chk("rst hsync", lcd_hsync, 32'h1);
    chk("rst vsync", lcd_vsync, 32'h1);
    chk("rst ceb", vram_ceb, 32'h0);
    chk("rst adb", vram_adb, 32'h0);
    chk("rst font_addr", font_addr, 32'h0);
    repeat (3) @(negedge clk);
    de_in = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    reset = 1'b0;
    sb.delete();
    m_line = 0;
    m_pix = 0;
    m_frames = 0;
    m_prev_de = 1'b0;
    m_prev_vs = 1'b0;
    #1;
  endtask

  typedef struct {
    logic        de;
    logic        vs;
    logic [15:0] rgb;
    logic [9:0]  adb;
    logic        ceb;
  } vec_t;

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[14];
    tab[0]  = '{1'b0, 1'b0, 16'h0, 10'd0, 1'b0};
    tab[1]  = '{1'b0, 1'b0, 16'h0, 10'd0, 1'b0};
    tab[2]  = '{1'b0, 1'b1, 16'h0, 10'd0, 1'b0};
    tab[3]  = '{1'b1, 1'b1, FG,    10'd0, 1'b1};
    tab[4]  = '{1'b1, 1'b1, BG,    10'd0, 1'b1};
    tab[5]  = '{1'b1, 1'b1, FG,    10'd0, 1'b1};
    tab[6]  = '{1'b1, 1'b1, BG,    10'd0, 1'b1};
    tab[7]  = '{1'b1, 1'b1, BG,    10'd0, 1'b1};
    tab[8]  = '{1'b1, 1'b1, FG,    10'd0, 1'b1};
    tab[9]  = '{1'b1, 1'b1, BG,    10'd0, 1'b1};
    tab[10] = '{1'b1, 1'b1, FG,    10'd0, 1'b1};
    tab[11] = '{1'b1, 1'b1, BG,    10'd1, 1'b1};
    tab[12] = '{1'b0, 1'b1, 16'h0, 10'd1, 1'b0};
    tab[13] = '{1'b0, 1'b1, 16'h0, 10'd0, 1'b0};

    @(negedge clk);
    #1;
    phase = 0;
    do_reset();

    // partial line, then reset in the middle of it with de still high
    do_vsync();
    do_line(16);
    for (int i = 0; i < 4; i++) px_cyc(1'b1);
    do_reset();

    phase = 1;
    for (int i = 0; i < 14; i++) begin
      cyc(tab[i].de, 1'b1, tab[i].vs, 1'b1, tab[i].rgb);
      chk($sformatf("tab adb %0d", i), vram_adb, tab[i].adb);
      chk($sformatf("tab ceb %0d", i), vram_ceb, tab[i].ceb);
    end
    do_line(16);

    phase = 2;
    do_vsync();
    for (int l = 0; l < 276; l++) do_line(8);

    phase = 3;
    do_vsync();
    do_line(500);
    do_line(8);

    phase = 4;
    do_vsync();
    for (int l = 0; l < 17; l++) do_line(8);
    for (int i = 0; i < 4; i++) px_cyc(1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("simul adb cleared", vram_adb, 32'd0);
    do_line(8);
    do_line(8);

    phase = 5;
    cursor_en = 1'b1;
    cursor_addr = 10'd61;
    for (int f = 0; f < 34; f++) begin
      do_vsync();
      for (int l = 0; l < 18; l++) do_line(16);
    end
    for (int i = 0; i < 3; i++) px_cyc(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
